sap_controller: RTL and testbench



---
 rtl/sap_pkg.sv | 53 +++++
 rtl/sap_alu.sv | 17 +
 rtl/sap_controller.sv | 86 ++++++++
 tb/tb_sap_controller.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-1 timing-and-control core: opcodes, microcode
// stages, control-word bit positions and the control words each stage emits.
package sap_pkg;

    // Instruction opcodes (upper nibble of the instruction register).
    typedef enum logic [3:0] {
        OP_LDA = 4'b0000,
        OP_ADD = 4'b0001,
        OP_SUB = 4'b0010,
        OP_HLT = 4'b1111
    } opcode_e;

    // Microcode stages; the counter wraps from LAST_STAGE back to T0.
    localparam logic [2:0] T0         = 3'd0;
    localparam logic [2:0] T1         = 3'd1;
    localparam logic [2:0] T2         = 3'd2;
    localparam logic [2:0] T3         = 3'd3;
    localparam logic [2:0] T4         = 3'd4;
    localparam logic [2:0] T5         = 3'd5;
    localparam logic [2:0] LAST_STAGE = T5;

    // Bit positions inside the 12-bit control word.
    localparam int CTRL_HLT       = 11;
    localparam int CTRL_PC_INC    = 10;
    localparam int CTRL_PC_EN     = 9;
    localparam int CTRL_MAR_LOAD  = 8;
    localparam int CTRL_MEM_EN    = 7;
    localparam int CTRL_IR_LOAD   = 6;
    localparam int CTRL_IR_EN     = 5;
    localparam int CTRL_A_LOAD    = 4;
    localparam int CTRL_A_EN      = 3;
    localparam int CTRL_B_LOAD    = 2;
    localparam int CTRL_ADDER_SUB = 1;
    localparam int CTRL_ADDER_EN  = 0;

    // Control words emitted by the microcode sequencer.
    localparam logic [11:0] CTRL_NOP   = 12'h000;
    localparam logic [11:0] FETCH0     = 12'h300; // pc_en | mar_load
    localparam logic [11:0] FETCH1     = 12'h400; // pc_inc
    localparam logic [11:0] FETCH2     = 12'h0C0; // mem_en | ir_load
    localparam logic [11:0] EXEC3_ADDR = 12'h120; // ir_en | mar_load
    localparam logic [11:0] EXEC3_HLT  = 12'h800; // hlt
    localparam logic [11:0] EXEC4_LDA  = 12'h090; // mem_en | a_load
    localparam logic [11:0] EXEC4_LDB  = 12'h084; // mem_en | b_load
    localparam logic [11:0] EXEC5_ADD  = 12'h011; // adder_en | a_load
    localparam logic [11:0] EXEC5_SUB  = 12'h013; // adder_sub | adder_en | a_load

    // Successor of a stage, wrapping after LAST_STAGE (unreachable codes wrap too).
    function automatic logic [2:0] next_stage(input logic [2:0] cur);
        return (cur >= LAST_STAGE) ? T0 : cur + 3'd1;
    endfunction

endpackage

// File: rtl/sap_alu.sv
// Combinational WIDTH-bit adder/subtractor feeding register A over the bus.
// The result wraps modulo 2^WIDTH; no carry or flags are produced.
module sap_alu #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] result
);

    // Select add or two's-complement subtract.
    always_comb begin
        result = sub ? (a - b) : (a + b);
    end

endmodule

// File: rtl/sap_controller.sv
// SAP-1 timing and control: stage counter clocked on the falling edge of the
// free-running clock, combinational microcode decoder, halt clock gate and ALU.
module sap_controller
    import sap_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             clk_out,
    output logic [11:0]      ctrl,
    output logic [WIDTH-1:0] alu_out,
    output logic [2:0]       stage
);

    logic [2:0] stage_q;
    logic [2:0] stage_d;
    logic       hlt;

    assign hlt = ctrl[CTRL_HLT];

    // Microcode decode: fetch stages ignore the opcode, which is only valid from T3.
    always_comb begin
        // NOTE: default first so every path assigns ctrl and no latch is inferred.
        ctrl = CTRL_NOP;
        case (stage_q)
            T0: ctrl = FETCH0;
            T1: ctrl = FETCH1;
            T2: ctrl = FETCH2;
            T3: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB: ctrl = EXEC3_ADDR;
                    OP_HLT:                 ctrl = EXEC3_HLT;
                    default:                ctrl = CTRL_NOP;
                endcase
            end
            T4: begin
                case (opcode)
                    OP_LDA:         ctrl = EXEC4_LDA;
                    OP_ADD, OP_SUB: ctrl = EXEC4_LDB;
                    default:        ctrl = CTRL_NOP;
                endcase
            end
            T5: begin
                case (opcode)
                    OP_ADD:  ctrl = EXEC5_ADD;
                    OP_SUB:  ctrl = EXEC5_SUB;
                    default: ctrl = CTRL_NOP;
                endcase
            end
            default: ctrl = CTRL_NOP;
        endcase
    end

    // Next stage: advance unless halted; reset handled in the register.
    always_comb begin
        stage_d = hlt ? stage_q : next_stage(stage_q);
    end

    // Stage register on the ungated clock's falling edge so reset still works while halted.
    always_ff @(negedge clk_in) begin
        // NOTE: non-blocking assignment for sequential state avoids simulation races.
        if (rst) begin
            stage_q <= T0;
        end else begin
            stage_q <= stage_d;
        end
    end

    // hlt only changes after a falling edge while clk_in is low, so no runt pulse.
    assign clk_out = clk_in & ~hlt;
    assign stage   = stage_q;

    sap_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a      (a),
        .b      (b),
        .sub    (ctrl[CTRL_ADDER_SUB]),
        .result (alu_out)
    );

endmodule

// File: tb/tb_sap_controller.sv
// Self-checking bench for sap_controller: table-driven microcode/ALU vectors
// through a scoreboard queue, plus hand-written halt and reset-abort sequences.
module tb_sap_controller;

    logic       clk_in;
    logic       rst;
    logic [3:0] opcode;
    logic [7:0] a;
    logic [7:0] b;
    logic       clk_out;
    logic [11:0] ctrl;
    logic [7:0] alu_out;
    logic [2:0] stage;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [2:0]  exp_stage;
        logic [11:0] exp_ctrl;
        logic [7:0]  exp_alu;
    } vec_t;

    typedef struct {
        logic [2:0]  stage;
        logic [11:0] ctrl;
        logic [7:0]  alu;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    sap_controller #(.WIDTH(8)) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .opcode  (opcode),
        .a       (a),
        .b       (b),
        .clk_out (clk_out),
        .ctrl    (ctrl),
        .alu_out (alu_out),
        .stage   (stage)
    );

    initial clk_in = 1'b1;
    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: run time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next falling edge (stage update point).
    task automatic step();
        @(negedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [7:0] va, input logic [7:0] vb,
                                input logic [2:0] st, input logic [11:0] c, input logic [7:0] r);
        vec_t v;
        v.op = op; v.a = va; v.b = vb; v.exp_stage = st; v.exp_ctrl = c; v.exp_alu = r;
        return v;
    endfunction

    initial begin
        rst = 1'b1;
        opcode = 4'b0000;
        a = 8'h00;
        b = 8'h00;

        // LDA: a+b with sub=0 -> 0x08
        vecs.push_back(mk(4'h0, 8'h05, 8'h03, 3'd0, 12'h300, 8'h08));
        vecs.push_back(mk(4'h0, 8'h05, 8'h03, 3'd1, 12'h400, 8'h08));
        vecs.push_back(mk(4'h0, 8'h05, 8'h03, 3'd2, 12'h0C0, 8'h08));
        vecs.push_back(mk(4'h0, 8'h05, 8'h03, 3'd3, 12'h120, 8'h08));
        vecs.push_back(mk(4'h0, 8'h05, 8'h03, 3'd4, 12'h090, 8'h08));
        vecs.push_back(mk(4'h0, 8'h05, 8'h03, 3'd5, 12'h000, 8'h08));
        // ADD: 0xFF+0x01 wraps to 0x00
        vecs.push_back(mk(4'h1, 8'hFF, 8'h01, 3'd0, 12'h300, 8'h00));
        vecs.push_back(mk(4'h1, 8'hFF, 8'h01, 3'd1, 12'h400, 8'h00));
        vecs.push_back(mk(4'h1, 8'hFF, 8'h01, 3'd2, 12'h0C0, 8'h00));
        vecs.push_back(mk(4'h1, 8'hFF, 8'h01, 3'd3, 12'h120, 8'h00));
        vecs.push_back(mk(4'h1, 8'hFF, 8'h01, 3'd4, 12'h084, 8'h00));
        vecs.push_back(mk(4'h1, 8'hFF, 8'h01, 3'd5, 12'h011, 8'h00));
        // SUB: 0x05-0x03 = 0x02 at stage 5 (sum elsewhere)
        vecs.push_back(mk(4'h2, 8'h05, 8'h03, 3'd0, 12'h300, 8'h08));
        vecs.push_back(mk(4'h2, 8'h05, 8'h03, 3'd1, 12'h400, 8'h08));
        vecs.push_back(mk(4'h2, 8'h05, 8'h03, 3'd2, 12'h0C0, 8'h08));
        vecs.push_back(mk(4'h2, 8'h05, 8'h03, 3'd3, 12'h120, 8'h08));
        vecs.push_back(mk(4'h2, 8'h05, 8'h03, 3'd4, 12'h084, 8'h08));
        vecs.push_back(mk(4'h2, 8'h05, 8'h03, 3'd5, 12'h013, 8'h02));
        // SUB: 0x00-0x01 wraps to 0xFF
        vecs.push_back(mk(4'h2, 8'h00, 8'h01, 3'd0, 12'h300, 8'h01));
        vecs.push_back(mk(4'h2, 8'h00, 8'h01, 3'd1, 12'h400, 8'h01));
        vecs.push_back(mk(4'h2, 8'h00, 8'h01, 3'd2, 12'h0C0, 8'h01));
        vecs.push_back(mk(4'h2, 8'h00, 8'h01, 3'd3, 12'h120, 8'h01));
        vecs.push_back(mk(4'h2, 8'h00, 8'h01, 3'd4, 12'h084, 8'h01));
        vecs.push_back(mk(4'h2, 8'h00, 8'h01, 3'd5, 12'h013, 8'hFF));
        // Undefined opcode 0111: NOP in stages 3-5, counter still wraps
        vecs.push_back(mk(4'h7, 8'h12, 8'h34, 3'd0, 12'h300, 8'h46));
        vecs.push_back(mk(4'h7, 8'h12, 8'h34, 3'd1, 12'h400, 8'h46));
        vecs.push_back(mk(4'h7, 8'h12, 8'h34, 3'd2, 12'h0C0, 8'h46));
        vecs.push_back(mk(4'h7, 8'h12, 8'h34, 3'd3, 12'h000, 8'h46));
        vecs.push_back(mk(4'h7, 8'h12, 8'h34, 3'd4, 12'h000, 8'h46));
        vecs.push_back(mk(4'h7, 8'h12, 8'h34, 3'd5, 12'h000, 8'h46));
        vecs.push_back(mk(4'h0, 8'h05, 8'h03, 3'd0, 12'h300, 8'h08));

        // Reset state
        do_reset();
        check("reset_stage", 32'(stage), 32'd0);
        check("reset_ctrl", 32'(ctrl), 32'h300);
        @(posedge clk_in); #1;
        check("reset_clk_out_high", 32'(clk_out), 32'd1);
        step();
        do_reset();

        // Table-driven run through the scoreboard
        for (int i = 0; i < vecs.size(); i++) begin
            exp_t e;
            opcode = vecs[i].op;
            a = vecs[i].a;
            b = vecs[i].b;
            e.stage = vecs[i].exp_stage;
            e.ctrl  = vecs[i].exp_ctrl;
            e.alu   = vecs[i].exp_alu;
            sb.push_back(e);
            #1;
            e = sb.pop_front();
            check($sformatf("vec%0d_stage", i), 32'(stage), 32'(e.stage));
            check($sformatf("vec%0d_ctrl", i), 32'(ctrl), 32'(e.ctrl));
            check($sformatf("vec%0d_alu", i), 32'(alu_out), 32'(e.alu));
            @(posedge clk_in); #1;
            check($sformatf("vec%0d_clk_out", i), 32'(clk_out), 32'd1);
            step();
        end

        // Halt: freeze at stage 3 with clk_out low, exit only via reset
        do_reset();
        opcode = 4'hF;
        check("hlt_s0_ctrl", 32'(ctrl), 32'h300);
        step();
        check("hlt_s1_ctrl", 32'(ctrl), 32'h400);
        step();
        check("hlt_s2_ctrl", 32'(ctrl), 32'h0C0);
        @(posedge clk_in); #1;
        check("hlt_s2_clk_out", 32'(clk_out), 32'd1);
        step();
        check("hlt_s3_stage", 32'(stage), 32'd3);
        check("hlt_s3_ctrl", 32'(ctrl), 32'h800);
        for (int k = 0; k < 12; k++) begin
            @(posedge clk_in); #1;
            check($sformatf("hlt_clk_out_%0d", k), 32'(clk_out), 32'd0);
            step();
            check($sformatf("hlt_stage_%0d", k), 32'(stage), 32'd3);
        end
        do_reset();
        check("hlt_rst_stage", 32'(stage), 32'd0);
        check("hlt_rst_ctrl", 32'(ctrl), 32'h300);
        @(posedge clk_in); #1;
        check("hlt_rst_clk_out", 32'(clk_out), 32'd1);
        step();
        check("hlt_rst_next_stage", 32'(stage), 32'd1);
        check("hlt_rst_next_ctrl", 32'(ctrl), 32'h400);

        // Reset at stage 4 of an ADD aborts the instruction
        do_reset();
        opcode = 4'h1;
        step(); step(); step(); step();
        check("abort_s4_stage", 32'(stage), 32'd4);
        check("abort_s4_ctrl", 32'(ctrl), 32'h084);
        do_reset();
        check("abort_rst_stage", 32'(stage), 32'd0);
        check("abort_rst_ctrl", 32'(ctrl), 32'h300);
        check("abort_rst_bload", 32'(ctrl[2]), 32'd0);
        step();
        check("abort_next_stage", 32'(stage), 32'd1);
        check("abort_next_bload", 32'(ctrl[2]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
